// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline register with a one-entry skid buffer and flush.
// Optional PIPE_STAGE_PERF_EN adds stall_cnt/bubble_cnt performance counters.
module pipe_stage_buf #(
  parameter int                DATA_W        = 151,
  parameter logic [DATA_W-1:0] RST_VAL       = '0,
  parameter int                SKID_EN_DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);
  if (SKID_EN_DEPTH != 1) begin : g_bad_depth
    $error("pipe_stage_buf: SKID_EN_DEPTH must be 1");
  end
  logic              m_v_q, m_v_d, s_v_q, s_v_d;
  logic [DATA_W-1:0] m_d_q, m_d_d, s_d_q, s_d_d;
  logic              acc, drn;
  assign acc = in_valid & ~s_v_q;
  assign drn = m_v_q & out_ready;
  always_comb begin
    m_v_d = m_v_q;
    m_d_d = m_d_q;
    s_v_d = s_v_q;
    s_d_d = s_d_q;
    if (flush) begin
      m_v_d = 1'b0;
      m_d_d = RST_VAL;
      s_v_d = 1'b0;
      s_d_d = '0;
    end else if (!m_v_q) begin
      m_v_d = acc;
      m_d_d = acc ? in_data : m_d_q;
    end else if (!s_v_q) begin
      m_v_d = acc | ~drn;
      m_d_d = (drn & acc) ? in_data : m_d_q;
      s_v_d = ~drn & acc;
      s_d_d = (~drn & acc) ? in_data : s_d_q;
    end else if (drn) begin
      m_d_d = s_d_q;
      s_v_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m_v_q <= 1'b0;
      m_d_q <= RST_VAL;
      s_v_q <= 1'b0;
      s_d_q <= '0;
    end else begin
      m_v_q <= m_v_d;
      m_d_q <= m_d_d;
      s_v_q <= s_v_d;
      s_d_q <= s_d_d;
    end
  end
  assign in_ready  = ~s_v_q;
  assign out_valid = m_v_q;
  assign out_data  = m_d_q;
  assign occupancy = {1'b0, m_v_q} + {1'b0, s_v_q};
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_q, bubble_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_q + {31'h0, m_v_q & ~out_ready};
      bubble_q <= bubble_q + {31'h0, ~m_v_q};
    end
  end
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: queue-model scoreboard bench for pipe_stage_buf.
module tb_pipe_stage_buf;
  localparam int W = 151;
  localparam logic [W-1:0] RV = {119'h0, 32'h1C00_0000};
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0] occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;
  int unsigned m_stall = 0, m_bubble = 0;
`endif
  int n_cmp = 0, n_fail = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] last = RV;
  bit chk_en = 0, pre_rdy = 1;

  pipe_stage_buf #(.DATA_W(W), .RST_VAL(RV), .SKID_EN_DEPTH(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of depth 2 whose head is out_data;
  // when empty, out_data shows the last value handed downstream (or RV after rst/flush).
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      last = RV;
      chk_en = 1;
`ifdef PIPE_STAGE_PERF_EN
      m_stall = 0;
      m_bubble = 0;
`endif
    end else if (flush) begin
      q.delete();
      last = RV;
    end else if (in_valid && pre_rdy) q.push_back(in_data);
  end

  // Monitor: compares visible state, then retires the head when downstream takes it.
  always @(negedge clk) begin
    if (chk_en) begin
      check("occupancy", W'(occupancy), W'(q.size()));
      check("out_valid", W'(out_valid), W'(q.size() > 0));
      check("in_ready", W'(in_ready), W'(q.size() < 2));
      check("out_data", out_data, q.size() > 0 ? q[0] : last);
`ifdef PIPE_STAGE_PERF_EN
      check("stall_cnt", W'(stall_cnt), W'(m_stall));
      check("bubble_cnt", W'(bubble_cnt), W'(m_bubble));
      if (!rst) begin
        if (q.size() == 0) m_bubble++;
        else if (!out_ready) m_stall++;
      end
`endif
      pre_rdy = q.size() < 2;
      if (!rst && !flush && q.size() > 0 && out_ready) last = q.pop_front();
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f, input logic rs);
    in_valid = v;
    in_data = d;
    out_ready = r;
    flush = f;
    rst = rs;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd();
    return W'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  initial begin
    drive(1, W'(8'hAB), 0, 0, 1);
    drive(1, W'(8'hAB), 0, 0, 1);
    check("reset out_data", out_data, RV);
    check("reset in_ready", W'(in_ready), W'(1));
    // stream
    drive(1, W'(1), 1, 0, 0);
    drive(1, W'(2), 1, 0, 0);
    drive(1, W'(3), 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    // backpressure
    drive(1, W'(8'h10), 0, 0, 0);
    drive(1, W'(8'h11), 0, 0, 0);
    check("bp occupancy", W'(occupancy), W'(2));
    check("bp in_ready", W'(in_ready), W'(0));
    drive(0, '0, 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    drive(0, '0, 1, 0, 0);
    // flush with a full stage and a beat offered
    drive(1, W'(8'h30), 0, 0, 0);
    drive(1, W'(8'h31), 0, 0, 0);
    drive(1, W'(8'h55), 0, 1, 0);
    check("flush out_data", out_data, RV);
    check("flush occupancy", W'(occupancy), W'(0));
    drive(0, '0, 1, 0, 0);
    // simultaneous drain and accept at occupancy 1
    drive(1, W'(8'h20), 0, 0, 0);
    drive(1, W'(8'h21), 1, 0, 0);
    check("simul out_data", out_data, W'(8'h21));
    check("simul occupancy", W'(occupancy), W'(1));
    drive(0, '0, 1, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 9) < 7, rnd(), $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3, $urandom_range(0, 199) < 1);
    drive(0, '0, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
